// File: rtl/imem_loader.sv
// imem_loader: receives a framed little-endian byte stream (word count,
// payload words, checksum), writes the payload into instruction memory one
// word at a time and releases the core reset only after the checksum matches.
module imem_loader #(
  parameter int INSTR_MEM_WORDS = 256,
  parameter int ADDR_W          = 10
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  // Word index width: byte address minus the two always-zero lane bits.
  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t            r_state;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_asm;
  logic [IDX_W-1:0]  r_index;
  logic [IDX_W-1:0]  r_last;
  logic [31:0]       r_sum;
  logic              r_s_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_core_rst_n;
  logic              r_load_done;
  logic              r_load_err;

  logic              w_accept;
  logic              w_last_byte;
  logic [31:0]       w_field;
  logic              w_count_bad;

  // The byte being accepted completes the field when it lands in lane 3, so
  // the full 32-bit value is the new byte on top of the three held lanes.
  assign w_accept    = s_valid && r_s_ready;
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_field     = {s_data, r_asm};
  assign w_count_bad = (w_field == 32'd0) || (w_field > 32'(INSTR_MEM_WORDS));

  // Frame FSM: lane assembly, word writes, checksum and all registered outputs.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state      <= ST_HDR;
      r_byte_cnt   <= 2'd0;
      r_asm        <= 24'd0;
      r_index      <= '0;
      r_last       <= '0;
      r_sum        <= 32'd0;
      r_s_ready    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
      r_core_rst_n <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      // Loading states accept bytes; this also raises s_ready right after reset.
      if (r_state != ST_DONE && r_state != ST_ERR) begin
        r_s_ready <= 1'b1;
      end

      if (reload) begin
        // Restart from the header; any byte offered this cycle is dropped.
        r_state      <= ST_HDR;
        r_byte_cnt   <= 2'd0;
        r_asm        <= 24'd0;
        r_index      <= '0;
        r_last       <= '0;
        r_sum        <= 32'd0;
        r_s_ready    <= 1'b1;
        r_core_rst_n <= 1'b0;
        r_load_done  <= 1'b0;
        r_load_err   <= 1'b0;
      end else if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (!w_last_byte) begin
          case (r_byte_cnt)
            2'd0:    r_asm[7:0]   <= s_data;
            2'd1:    r_asm[15:8]  <= s_data;
            default: r_asm[23:16] <= s_data;
          endcase
        end else begin
          case (r_state)
            ST_HDR: begin
              if (w_count_bad) begin
                r_state    <= ST_ERR;
                r_s_ready  <= 1'b0;
                r_load_err <= 1'b1;
              end else begin
                r_state <= ST_DATA;
                r_index <= '0;
                r_sum   <= 32'd0;
                r_last  <= IDX_W'(w_field - 32'd1);
              end
            end
            ST_DATA: begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {r_index, 2'b00};
              r_mem_wdata <= w_field;
              r_sum       <= r_sum + w_field;
              r_index     <= r_index + IDX_W'(1);
              if (r_index == r_last) begin
                r_state <= ST_CSUM;
              end
            end
            ST_CSUM: begin
              r_s_ready <= 1'b0;
              if (w_field == r_sum) begin
                r_state      <= ST_DONE;
                r_load_done  <= 1'b1;
                r_core_rst_n <= 1'b1;
              end else begin
                r_state    <= ST_ERR;
                r_load_err <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign s_ready    = r_s_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign core_rst_n = r_core_rst_n;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: byte-stream frames with random valid gaps,
// checked every cycle against a frame-level model, plus literal expectations.
module tb_imem_loader;
  localparam int WORDS = 256;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          areset_n = 1'b1;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'd0;
  logic          reload = 1'b0;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rst_n;
  logic          load_done;
  logic          load_err;

  always #5 clk = ~clk;

  imem_loader #(.INSTR_MEM_WORDS(WORDS), .ADDR_W(AW)) dut (
    .clk(clk), .areset_n(areset_n), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_rst_n(core_rst_n), .load_done(load_done),
    .load_err(load_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [7:0]    m_bytes[$];
  logic [31:0]   m_n, m_sum, m_exp_data;
  logic [AW-1:0] m_exp_addr;
  bit            m_we_pend, m_fin, m_done, m_err, m_nok, m_fresh;
  bit            exp_ready;

  typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
  wr_t wlog[$];

  function automatic logic [31:0] le32(input int p);
    return {m_bytes[p+3], m_bytes[p+2], m_bytes[p+1], m_bytes[p]};
  endfunction

  task automatic model_clear();
    m_bytes.delete();
    m_n = 0; m_sum = 0; m_exp_data = 0; m_exp_addr = 0;
    m_we_pend = 0; m_fin = 0; m_done = 0; m_err = 0; m_nok = 0;
  endtask

  // Per-cycle compare of every output against the model, then model advance.
  always @(negedge clk) begin
    if (!areset_n) begin
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_load_err", 32'(load_err), 32'd0);
      model_clear();
      m_fresh = 1;
    end else begin
      exp_ready = !m_fresh && !m_fin;
      check("s_ready", 32'(s_ready), 32'(exp_ready));
      check("mem_we", 32'(mem_we), 32'(m_we_pend));
      if (m_we_pend) begin
        check("mem_addr", 32'(mem_addr), 32'(m_exp_addr));
        check("mem_wdata", mem_wdata, m_exp_data);
      end
      check("load_done", 32'(load_done), 32'(m_done));
      check("load_err", 32'(load_err), 32'(m_err));
      check("core_rst_n", 32'(core_rst_n), 32'(m_done));
      if (mem_we) wlog.push_back('{a: mem_addr, d: mem_wdata});

      m_we_pend = 0;
      if (reload) begin
        model_clear();
      end else if (s_valid && exp_ready) begin
        int cnt;
        int k;
        m_bytes.push_back(s_data);
        cnt = m_bytes.size();
        if (cnt == 4) begin
          m_n = le32(0);
          if (m_n == 0 || m_n > WORDS) begin
            m_fin = 1; m_err = 1;
          end else begin
            m_nok = 1;
          end
        end else if (cnt > 4 && cnt % 4 == 0 && m_nok) begin
          k = (cnt - 4) / 4 - 1;
          if (k < int'(m_n)) begin
            m_we_pend  = 1;
            m_exp_addr = AW'(k * 4);
            m_exp_data = le32(cnt - 4);
            m_sum      = m_sum + m_exp_data;
          end else begin
            m_fin = 1;
            if (le32(cnt - 4) == m_sum) m_done = 1;
            else m_err = 1;
          end
        end
      end
      m_fresh = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0]  fr[$];
  logic [31:0] words[$];

  task automatic push32(input logic [31:0] v);
    for (int b = 0; b < 4; b++) fr.push_back(v[8*b +: 8]);
  endtask

  task automatic make_frame(input int n, input bit corrupt);
    logic [31:0] sum;
    logic [31:0] w;
    fr.delete(); words.delete();
    sum = 0;
    push32(32'(n));
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      words.push_back(w);
      push32(w);
      sum = sum + w;
    end
    push32(corrupt ? sum + 32'd1 : sum);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers fr[0..nbytes-1] with valid asserted pct% of cycles.
  task automatic send(input int nbytes, input int pct);
    int idx;
    int budget;
    bit acc;
    idx = 0;
    budget = 20000;
    while (idx < nbytes && budget > 0) begin
      s_data  = fr[idx];
      s_valid = ($urandom_range(99) < pct);
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      budget--;
    end
    s_valid = 1'b0;
    check("send_complete", 32'(idx), 32'(nbytes));
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    idle(1);
    reload = 1'b0;
  endtask

  task automatic check_log_vs_words(input string tag);
    check({tag, "_nwrites"}, 32'(wlog.size()), 32'(words.size()));
    for (int k = 0; k < wlog.size() && k < words.size(); k++) begin
      check({tag, "_addr"}, 32'(wlog[k].a), 32'(k * 4));
      check({tag, "_data"}, wlog[k].d, words[k]);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    #2 areset_n = 1'b0;
    idle(3);
    areset_n = 1'b1;
    idle(2);

    // Two-word frame, good checksum, continuous valid.
    fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
           8'h13, 8'h01, 8'hA0, 8'h00, 8'hA6, 8'h01, 8'hF0, 8'h00};
    wlog.delete();
    send(16, 100);
    idle(3);
    check("t1_nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check("t1_w0_addr", 32'(wlog[0].a), 32'h000);
      check("t1_w0_data", wlog[0].d, 32'h00500093);
      check("t1_w1_addr", 32'(wlog[1].a), 32'h004);
      check("t1_w1_data", wlog[1].d, 32'h00A00113);
    end
    check("t1_done", 32'(load_done), 32'd1);
    check("t1_core", 32'(core_rst_n), 32'd1);
    check("t1_ready", 32'(s_ready), 32'd0);

    // Reload after DONE, then one-word frame.
    pulse_reload();
    check("rl_core", 32'(core_rst_n), 32'd0);
    check("rl_done", 32'(load_done), 32'd0);
    fr = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h13, 8'h00, 8'h00, 8'h00};
    wlog.delete();
    send(12, 100);
    idle(3);
    check("t6_nwrites", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) begin
      check("t6_addr", 32'(wlog[0].a), 32'h000);
      check("t6_data", wlog[0].d, 32'h00000013);
    end
    check("t6_done", 32'(load_done), 32'd1);

    // Bad checksum.
    pulse_reload();
    fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
           8'h13, 8'h01, 8'hA0, 8'h00, 8'hA7, 8'h01, 8'hF0, 8'h00};
    wlog.delete();
    send(16, 100);
    idle(3);
    check("t2_nwrites", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      check("t2_w1_addr", 32'(wlog[1].a), 32'h004);
      check("t2_w1_data", wlog[1].d, 32'h00A00113);
    end
    check("t2_err", 32'(load_err), 32'd1);
    check("t2_done", 32'(load_done), 32'd0);
    check("t2_core", 32'(core_rst_n), 32'd0);

    // N == 0 and N == 257 headers.
    pulse_reload();
    fr = '{8'h00, 8'h00, 8'h00, 8'h00};
    wlog.delete();
    send(4, 100);
    idle(3);
    check("t3_err", 32'(load_err), 32'd1);
    check("t3_nwrites", 32'(wlog.size()), 32'd0);
    pulse_reload();
    fr = '{8'h01, 8'h01, 8'h00, 8'h00};
    send(4, 100);
    idle(3);
    check("t4_err", 32'(load_err), 32'd1);
    check("t4_nwrites", 32'(wlog.size()), 32'd0);

    // Random frames with ~50% valid gaps; one with a corrupted checksum.
    for (int f = 0; f < 6; f++) begin
      bit bad;
      bad = (f == 3);
      pulse_reload();
      make_frame($urandom_range(1, 12), bad);
      wlog.delete();
      send(fr.size(), 50);
      idle(3);
      check_log_vs_words("rnd");
      check("rnd_done", 32'(load_done), 32'(!bad));
      check("rnd_err", 32'(load_err), 32'(bad));
    end

    // Full-depth frame: last write lands at the top word address.
    pulse_reload();
    make_frame(WORDS, 1'b0);
    wlog.delete();
    send(fr.size(), 100);
    idle(3);
    check("max_nwrites", 32'(wlog.size()), 32'(WORDS));
    if (wlog.size() == WORDS) check("max_last_addr", 32'(wlog[WORDS-1].a), 32'h3FC);
    check("max_done", 32'(load_done), 32'd1);

    // Asynchronous reset after the 6th byte, then a full reload from address 0.
    pulse_reload();
    make_frame(3, 1'b0);
    send(6, 100);
    areset_n = 1'b0;
    #1;
    check("ar_s_ready", 32'(s_ready), 32'd0);
    check("ar_mem_addr", 32'(mem_addr), 32'd0);
    check("ar_mem_wdata", mem_wdata, 32'd0);
    check("ar_core", 32'(core_rst_n), 32'd0);
    idle(2);
    areset_n = 1'b1;
    wlog.delete();
    send(fr.size(), 60);
    idle(3);
    check_log_vs_words("ar");
    check("ar_done", 32'(load_done), 32'd1);

    // Reload mid-header with a byte offered the same cycle; that byte is dropped.
    pulse_reload();
    make_frame(2, 1'b0);
    send(2, 100);
    reload  = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    idle(1);
    reload  = 1'b0;
    s_valid = 1'b0;
    wlog.delete();
    send(fr.size(), 70);
    idle(3);
    check_log_vs_words("rlb");
    check("rlb_done", 32'(load_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the bench's memory dump path: it fills instruction memory from a byte stream before the core runs.
- Accepts a framed little-endian byte stream from the host side (UART bridge or bench driver), assembles 32-bit words and issues word writes to the instruction memory port.
- Holds the rv32i core in reset until a complete, checksum-verified image is loaded.
- Sits between the host interface and `top`'s instruction memory write port and core reset.

Parameters:
- INSTR_MEM_WORDS, 256, instruction memory depth in 32-bit words.
- ADDR_W, 10, byte-address width of mem_addr; must equal clog2(INSTR_MEM_WORDS*4).

Ports:
- clk  in  1  system clock, rising edge.
- areset_n  in  1  asynchronous active-low reset.
- s_valid  in  1  host byte valid.
- s_data  in  8  host byte.
- s_ready  out  1  loader can accept a byte.
- reload  in  1  single-cycle pulse; restart loading from header.
- mem_we  out  1  instruction memory word write strobe.
- mem_addr  out  ADDR_W  byte address of the write, word aligned (bits [1:0]=0).
- mem_wdata  out  32  write data.
- core_rst_n  out  1  core reset, active low.
- load_done  out  1  image loaded and checksum matched.
- load_err  out  1  framing or checksum error.

Behaviour:
- Frame format: 4-byte word count N (LE), then N*4 payload bytes (LE words, word k goes to byte address 4k), then a 4-byte checksum (LE).
  - Checksum = sum of all N payload words mod 2^32.
- A byte is accepted on a clk edge where s_valid && s_ready. s_data need not be held stable after acceptance. s_valid gaps of any length are legal.
- A 2-bit byte counter selects the lane; byte b of a field goes to bits [8b+7:8b].
- States: HDR, DATA, CSUM, DONE, ERR.
  - s_ready=1 in HDR, DATA and CSUM; s_ready=0 in DONE and ERR.
  - HDR: after the 4th header byte, latch N.
    - N==0 or N>INSTR_MEM_WORDS -> ERR.
    - Otherwise -> DATA, with word index=0 and sum=0.
  - DATA: on the 4th byte of each word, the next cycle asserts mem_we=1 for exactly 1 cycle, with mem_addr={index,2'b00} and mem_wdata=the assembled word.
    - sum += word; index++.
    - After word N-1 -> CSUM.
  - CSUM: on the 4th byte, compare with sum.
    - Equal -> DONE.
    - Else -> ERR.
    - The transition is visible the cycle after that byte is accepted.
  - DONE: load_done=1, core_rst_n=1.
  - ERR: load_err=1, core_rst_n=0.
- Write latency: mem_we asserts exactly 1 cycle after acceptance of the word's last byte. Back-to-back words every 4 cycles are supported.
- core_rst_n is registered and low in every state except DONE. It rises the cycle the state enters DONE.
- reload (any state): next cycle state=HDR and all counters, sum and flags clear; core_rst_n=0, load_done=0, load_err=0.
  - A byte presented in the same cycle as reload is discarded.
  - A pending mem_we from a word completed in the previous cycle is still issued.
- Reset (areset_n=0, asynchronous, any time including mid-DATA) clears all outputs immediately:
  - s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, load_done=0, load_err=0.
  - State returns to HDR.
  - s_ready rises in the first cycle after areset_n deasserts.
- mem_addr never exceeds (INSTR_MEM_WORDS-1)*4; index wrap is impossible by the N check.
- Sum arithmetic is 32-bit unsigned wrap-around; carry is discarded.

Test Plan:
- Stream 02 00 00 00 | 93 00 50 00 | 13 01 A0 00 | A6 01 F0 00, continuous valid -> writes (addr 0x000, 0x00500093) and (addr 0x004, 0x00A00113), each a 1-cycle mem_we; then load_done=1, core_rst_n=1, s_ready=0.
- Same frame with checksum A7 01 F0 00 -> the same two writes occur, then load_err=1, core_rst_n stays 0, load_done=0.
- Header 00 00 00 00 -> ERR, no mem_we. Header 01 01 00 00 (N=257 > 256) -> ERR, no mem_we.
- Valid frame with s_valid randomly deasserted (~50%) -> identical write sequence and final load_done=1; no byte lost or duplicated.
- Assert areset_n=0 after the 6th byte -> outputs clear immediately; a full valid frame sent afterwards loads correctly from addr 0.
- After DONE, pulse reload -> core_rst_n=0 and load_done=0 the next cycle; a new 1-word frame 01 00 00 00 | 13 00 00 00 | 13 00 00 00 writes (0x000, 0x00000013) and completes with DONE.
